multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_ctrl_pkg.sv | 101 ++++++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode/funct constants, ALUOp and ALU_control
// encodings, datapath mux selects and the packed control word.
package mips_ctrl_pkg;

  // State codes are architecturally visible on the debug port, so every
  // value is pinned explicitly rather than left to enum auto-numbering.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUOp: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // ALU_control: operation presented to the ALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RD2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Everything the FSM drives from its current state, in one word.
  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  // All enables off, ALU adding, operand selects at their zero codes.
  localparam ctrl_t CTRL_IDLE = '{
    iord:       1'b0,
    ir_write:   1'b0,
    mem_write:  1'b0,
    reg_dest:   1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    alu_srca:   1'b0,
    alu_srcb:   SRCB_RD2,
    pc_src:     PCSRC_ALU,
    alu_op:     ALUOP_ADD,
    pc_write:   1'b0,
    branch:     1'b0
  };

  // Loads and stores share the address-calculation state.
  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps the FSM's ALUOp plus the R-type funct field to ALU_control.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: ALUOp[1:0] from the FSM, funct[5:0] from the instruction register,
// ALU_control[2:0] to the ALU.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [2:0] ALU_control
);

  always_comb begin
    ALU_control = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALU_control = ALU_ADD;
      ALUOP_SUB: ALU_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ALU_control = ALU_ADD;
          FUNCT_SUB: ALU_control = ALU_SUB;
          FUNCT_AND: ALU_control = ALU_AND;
          FUNCT_OR:  ALU_control = ALU_OR;
          FUNCT_SLT: ALU_control = ALU_SLT;
          // Unsupported funct codes fall back to add so the ALU never sees
          // an undefined operation.
          default:   ALU_control = ALU_ADD;
        endcase
      end
      // The reserved encoding behaves like a plain add.
      default:   ALU_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j).
// Latency: 3-5 cycles per instruction with mem_ready high; fetch, load read and store stall per cycle of mem_ready low.
// Backpressure: mem_ready low holds FETCH, MEMRD and MEMWR, keeping their access enables asserted.
// Ports: clk/reset (async, active-high); opcode, funct, zero, mem_ready in;
// pc_en plus datapath selects/enables, ALU_control and debug state out.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IorD,
  output logic       IR_write,
  output logic       mem_write,
  output logic       reg_dest,
  output logic       memtoReg,
  output logic       reg_write,
  output logic       ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [1:0] PC_src,
  output logic [2:0] ALU_control,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register. Reset drops straight into FETCH without waiting for an
  // edge, which abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state control word.
  always_comb begin
    state_d = FETCH;
    ctrl    = CTRL_IDLE;
    case (state_q)
      FETCH: begin
        // PC+4 is computed every cycle, but IR and PC only load once the
        // instruction read actually completes.
        ctrl.alu_srcb = SRCB_FOUR;
        ctrl.alu_op   = ALUOP_ADD;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
        state_d       = mem_ready ? DECODE : FETCH;
      end

      DECODE: begin
        // Speculatively form the branch target while registers are read.
        ctrl.alu_srcb = SRCB_IMM_SH2;
        ctrl.alu_op   = ALUOP_ADD;
        if (is_mem_op(opcode)) begin
          state_d = MEMADR;
        end else begin
          case (opcode)
            OP_RTYPE: state_d = EXECUTE;
            OP_BEQ:   state_d = BRANCH;
            OP_ADDI:  state_d = ADDIEX;
            OP_J:     state_d = JUMP;
            default:  state_d = FETCH;
          endcase
        end
      end

      MEMADR: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.alu_op   = ALUOP_ADD;
        // Only lw and sw reach this state, so anything not lw is a store.
        state_d       = (opcode == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = mem_ready ? MEMWB : MEMRD;
      end

      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_d         = FETCH;
      end

      MEMWR: begin
        // The write strobe stays up for every cycle of the stall.
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        state_d        = mem_ready ? FETCH : MEMWR;
      end

      EXECUTE: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_RD2;
        ctrl.alu_op   = ALUOP_FUNCT;
        state_d       = ALUWB;
      end

      ALUWB: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = FETCH;
      end

      BRANCH: begin
        // Compare by subtraction; the target formed in DECODE sits in ALUOut.
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_RD2;
        ctrl.alu_op   = ALUOP_SUB;
        ctrl.pc_src   = PCSRC_ALUOUT;
        ctrl.branch   = 1'b1;
        state_d       = FETCH;
      end

      ADDIEX: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.alu_op   = ALUOP_ADD;
        state_d       = ADDIWB;
      end

      ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = FETCH;
      end

      JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
        state_d       = FETCH;
      end

      // Unused codes 12-15 recover to FETCH with everything idle.
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp       (ctrl.alu_op),
    .funct       (funct),
    .ALU_control (ALU_control)
  );

  // During reset the state is already FETCH, but FETCH's two mem_ready
  // qualified enables must not leak through, so they are gated explicitly.
  assign IR_write  = ctrl.ir_write & ~reset;
  assign pc_en     = (ctrl.pc_write | (ctrl.branch & zero)) & ~reset;

  assign IorD      = ctrl.iord;
  assign mem_write = ctrl.mem_write;
  assign reg_dest  = ctrl.reg_dest;
  assign memtoReg  = ctrl.mem_to_reg;
  assign reg_write = ctrl.reg_write;
  assign ALU_srcA  = ctrl.alu_srca;
  assign ALU_srcB  = ctrl.alu_srcb;
  assign PC_src    = ctrl.pc_src;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction walks with literal
// expectations, then randomized instruction/mem_ready/reset traffic checked
// every cycle against an instruction-path model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'b100011;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, IorD, IR_write, mem_write, reg_dest, memtoReg, reg_write, ALU_srcA;
  logic [1:0] ALU_srcB, PC_src;
  logic [2:0] ALU_control;
  logic [3:0] state;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .IorD        (IorD),
    .IR_write    (IR_write),
    .mem_write   (mem_write),
    .reg_dest    (reg_dest),
    .memtoReg    (memtoReg),
    .reg_write   (reg_write),
    .ALU_srcA    (ALU_srcA),
    .ALU_srcB    (ALU_srcB),
    .PC_src      (PC_src),
    .ALU_control (ALU_control),
    .state       (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // An instruction is the fetch/decode prologue followed by an opcode-
  // specific list of steps; the list is held as nibbles, next step lowest.
  // Fetch, load-read and store steps only complete when memory is ready.
  function automatic logic [31:0] path_of(input logic [5:0] op);
    case (op)
      6'b100011: return 32'h432;  // lw:   addr, read, writeback
      6'b101011: return 32'h52;   // sw:   addr, write
      6'b000000: return 32'h76;   // R:    execute, writeback
      6'b000100: return 32'h8;    // beq:  branch
      6'b001000: return 32'hA9;   // addi: execute, writeback
      6'b000010: return 32'hB;    // j:    jump
      default:   return 32'h0;    // unknown: straight back to fetch
    endcase
  endfunction

  logic [3:0]  cur = 4'd0;
  logic [31:0] rest = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= 4'd0;
      rest <= 32'd0;
    end else if ((cur == 4'd0 || cur == 4'd3 || cur == 4'd5) && !mem_ready) begin
      cur <= cur;
    end else if (cur == 4'd0) begin
      cur <= 4'd1;
    end else if (cur == 4'd1) begin
      {rest, cur} <= {4'h0, path_of(opcode)};
    end else begin
      {rest, cur} <= {4'h0, rest};
    end
  end

  function automatic logic [2:0] r_op(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  typedef struct packed {
    logic       pc_en, iord, irw, memw, rdst, m2r, regw, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
  } outs_t;

  // Expected outputs from the step the instruction is in.
  function automatic outs_t model_outs(input logic [3:0] st, input logic rst,
                                       input logic mr, input logic z, input logic [5:0] fn);
    outs_t o;
    o = '0;
    o.aluc = 3'b010;
    if (rst) begin
      o.srcb = 2'b01;
      return o;
    end
    case (st)
      4'd0:  begin o.srcb = 2'b01; o.irw = mr; o.pc_en = mr; end
      4'd1:  o.srcb = 2'b11;
      4'd2, 4'd9: begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd3:  o.iord = 1'b1;
      4'd4:  begin o.m2r = 1'b1; o.regw = 1'b1; end
      4'd5:  begin o.iord = 1'b1; o.memw = 1'b1; end
      4'd6:  begin o.srca = 1'b1; o.aluc = r_op(fn); end
      4'd7:  begin o.rdst = 1'b1; o.regw = 1'b1; end
      4'd8:  begin o.srca = 1'b1; o.pcsrc = 2'b01; o.aluc = 3'b110; o.pc_en = z; end
      4'd10: o.regw = 1'b1;
      4'd11: begin o.pcsrc = 2'b10; o.pc_en = 1'b1; end
      default: o = o;
    endcase
    return o;
  endfunction

  logic [14:0] act;
  assign act = {pc_en, IorD, IR_write, mem_write, reg_dest, memtoReg, reg_write,
                ALU_srcA, ALU_srcB, PC_src, ALU_control};

  // Single per-cycle compare against the model.
  always @(negedge clk) begin
    chk("model state", {28'd0, state}, {28'd0, cur});
    chk("model outputs", {17'd0, act}, {17'd0, model_outs(cur, reset, mem_ready, zero, funct)});
  end

  // ---------------------------------------------------------------- directed
  // Called at a negedge with the DUT in FETCH; runs n steps past that fetch.
  task automatic walk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [31:0] seq, input int n, input logic [15:0] mr_mask,
                      output logic [15:0] regw_b, output logic [15:0] memw_b,
                      output logic [15:0] pcen_b, output logic [15:0] m2r_b,
                      output logic [15:0] rdst_b, output logic [47:0] aluc_b);
    #1;
    opcode = op; funct = fn; zero = z; mem_ready = 1'b1;
    regw_b = '0; memw_b = '0; pcen_b = '0; m2r_b = '0; rdst_b = '0; aluc_b = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      mem_ready = mr_mask[i];
      @(negedge clk);
      chk($sformatf("%s step%0d state", nm, i), {28'd0, state}, {28'd0, seq[4*i +: 4]});
      regw_b[i] = reg_write;
      memw_b[i] = mem_write;
      pcen_b[i] = pc_en;
      m2r_b[i]  = memtoReg;
      rdst_b[i] = reg_dest;
      aluc_b[3*i +: 3] = ALU_control;
    end
  endtask

  logic [15:0] rw, mw, pe, mr2, rd;
  logic [47:0] ac;

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset state", {28'd0, state}, 32'd0);
    chk("reset ALU_srcB", {30'd0, ALU_srcB}, 32'd1);
    chk("reset ALU_control", {29'd0, ALU_control}, 32'd2);
    chk("reset pc_en/IR_write", {30'd0, pc_en, IR_write}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post-reset fetch", {28'd0, state}, 32'd0);

    walk("lw", 6'b100011, 6'd0, 1'b0, 32'h04321, 5, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("lw reg_write only in MEMWB", {16'd0, rw}, 32'h8);
    chk("lw memtoReg only in MEMWB", {16'd0, mr2}, 32'h8);
    chk("lw no mem_write", {16'd0, mw}, 32'h0);

    walk("slt", 6'b000000, 6'b101010, 1'b0, 32'h0761, 4, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("slt ALU_control in EXECUTE", {29'd0, ac[5:3]}, 32'h7);
    chk("slt reg_write in ALUWB", {16'd0, rw}, 32'h4);
    chk("slt reg_dest in ALUWB", {16'd0, rd}, 32'h4);

    walk("beq taken", 6'b000100, 6'd0, 1'b1, 32'h081, 3, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("beq taken pc_en", {16'd0, pe}, 32'h6);
    chk("beq ALU sub", {29'd0, ac[5:3]}, 32'h6);

    walk("beq not taken", 6'b000100, 6'd0, 1'b0, 32'h081, 3, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("beq not taken pc_en", {16'd0, pe}, 32'h4);

    walk("sw stall", 6'b101011, 6'd0, 1'b0, 32'h0555521, 7, 16'hFFE3, rw, mw, pe, mr2, rd, ac);
    chk("sw mem_write 4 cycles", {16'd0, mw}, 32'h3C);
    chk("sw no reg_write", {16'd0, rw}, 32'h0);

    walk("illegal", 6'b111111, 6'd0, 1'b0, 32'h01, 2, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("illegal no writes", {16'd0, rw | mw}, 32'h0);
    chk("illegal pc_en only at fetch", {16'd0, pe}, 32'h2);

    walk("addi", 6'b001000, 6'd0, 1'b0, 32'h0A91, 4, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("addi reg_write in ADDIWB", {16'd0, rw}, 32'h4);

    walk("j", 6'b000010, 6'd0, 1'b0, 32'h0B1, 3, 16'hFFFF, rw, mw, pe, mr2, rd, ac);
    chk("j pc_en", {16'd0, pe}, 32'h6);

    // Reset pulsed while a load waits in MEMRD.
    walk("lw abort", 6'b100011, 6'd0, 1'b0, 32'h321, 3, 16'hFFFB, rw, mw, pe, mr2, rd, ac);
    @(posedge clk);
    #2;
    chk("abort still MEMRD", {28'd0, state}, 32'd3);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("abort async state", {28'd0, state}, 32'd0);
    chk("abort enables", {26'd0, IorD, mem_write, reg_write, IR_write, pc_en, memtoReg}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    chk("abort first edge from FETCH", {28'd0, state}, 32'd1);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(63) == 0) reset = 1'b1;
      mem_ready = ($urandom_range(3) != 0);
      zero = 1'($urandom_range(1));
      if (cur == 4'd0) begin
        case ($urandom_range(6))
          0: opcode = 6'b100011;
          1: opcode = 6'b101011;
          2: opcode = 6'b000000;
          3: opcode = 6'b000100;
          4: opcode = 6'b001000;
          5: opcode = 6'b000010;
          default: opcode = 6'($urandom_range(63));
        endcase
        case ($urandom_range(5))
          0: funct = 6'b100000;
          1: funct = 6'b100010;
          2: funct = 6'b100100;
          3: funct = 6'b100101;
          4: funct = 6'b101010;
          default: funct = 6'($urandom_range(63));
        endcase
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
